// File: rtl/bp_be_dcache_pkt_encoder_if.sv
// Dcache request encoder: packet types and the request/packet/error bundle.
// Request side is valid/ready, packet side is valid/ready, error side is a bare pulse.
// The slave modport is the encoder's view; master is the view of the pipe plus dcache around it.
package bp_be_dcache_pkt_encoder_pkg;

  localparam int vaddr_width_p  = 39;
  localparam int dword_width_gp = 64;

  // The order matters: the encoder reaches size and AMO variants by offsetting from a base op.
  typedef enum logic [5:0] {
    e_dcache_op_lb = 6'd0, e_dcache_op_lh, e_dcache_op_lw, e_dcache_op_ld,
    e_dcache_op_lbu, e_dcache_op_lhu, e_dcache_op_lwu,
    e_dcache_op_sb, e_dcache_op_sh, e_dcache_op_sw, e_dcache_op_sd,
    e_dcache_op_lrw, e_dcache_op_lrd, e_dcache_op_scw, e_dcache_op_scd,
    e_dcache_op_amoswapw, e_dcache_op_amoaddw, e_dcache_op_amoxorw, e_dcache_op_amoandw,
    e_dcache_op_amoorw, e_dcache_op_amominw, e_dcache_op_amomaxw, e_dcache_op_amominuw,
    e_dcache_op_amomaxuw,
    e_dcache_op_amoswapd, e_dcache_op_amoaddd, e_dcache_op_amoxord, e_dcache_op_amoandd,
    e_dcache_op_amoord, e_dcache_op_amomind, e_dcache_op_amomaxd, e_dcache_op_amominud,
    e_dcache_op_amomaxud,
    e_dcache_op_flw, e_dcache_op_fld, e_dcache_op_fsw, e_dcache_op_fsd,
    e_dcache_op_fencei
  } bp_be_dcache_op_e;

  typedef struct packed {
    bp_be_dcache_op_e            opcode;
    logic [vaddr_width_p-1:0]    vaddr;
    logic [dword_width_gp-1:0]   data;
    logic                        no_amo_return;
  } bp_be_dcache_pkt_s;

endpackage

interface bp_be_dcache_pkt_encoder_if;
  import bp_be_dcache_pkt_encoder_pkg::*;

  logic                       req_v_i;
  logic                       req_ready_and_o;
  logic [2:0]                 req_class_i;
  logic [1:0]                 req_size_i;
  logic                       req_unsigned_i;
  logic [3:0]                 req_amo_i;
  logic                       req_no_return_i;
  logic [vaddr_width_p-1:0]   req_vaddr_i;
  logic [dword_width_gp-1:0]  req_data_i;
  logic                       pkt_v_o;
  bp_be_dcache_pkt_s          pkt_o;
  logic                       pkt_ready_and_i;
  logic                       err_v_o;
  logic                       err_illegal_o;
  logic                       err_misaligned_o;
  logic [vaddr_width_p-1:0]   err_vaddr_o;

  modport slave (
    input  req_v_i, req_class_i, req_size_i, req_unsigned_i, req_amo_i, req_no_return_i,
           req_vaddr_i, req_data_i, pkt_ready_and_i,
    output req_ready_and_o, pkt_v_o, pkt_o, err_v_o, err_illegal_o, err_misaligned_o, err_vaddr_o
  );

  modport master (
    output req_v_i, req_class_i, req_size_i, req_unsigned_i, req_amo_i, req_no_return_i,
           req_vaddr_i, req_data_i, pkt_ready_and_i,
    input  req_ready_and_o, pkt_v_o, pkt_o, err_v_o, err_illegal_o, err_misaligned_o, err_vaddr_o
  );

endinterface

// File: rtl/bp_be_dcache_pkt_encoder.sv
// Encodes classified memory requests into dcache packets, checks legality/alignment.
// Latency: packet or error visible 1 cycle after accept; no bypass through the FIFO.
// Backpressure: ready drops on a full FIFO (registered count), on fencei with a non-empty FIFO, and in FENCE.
module bp_be_dcache_pkt_encoder
  import bp_be_dcache_pkt_encoder_pkg::*;
#(
  parameter int els_p = 2
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  bp_be_dcache_pkt_encoder_if.slave   io
);

  localparam int ptr_w = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w = $clog2(els_p + 1);
  localparam logic [ptr_w-1:0] ptr_last = ptr_w'(els_p - 1);
  localparam logic [cnt_w-1:0] cnt_full = cnt_w'(els_p);

  typedef enum logic {e_run, e_fence} state_e;

  state_e                     state_q, state_d;
  bp_be_dcache_pkt_s          mem_q [els_p];
  bp_be_dcache_pkt_s          mem_d [els_p];
  logic [ptr_w-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [cnt_w-1:0]           count_q, count_d;
  logic                       err_v_q, err_v_d;
  logic                       err_illegal_q, err_illegal_d;
  logic                       err_misaligned_q, err_misaligned_d;
  logic [vaddr_width_p-1:0]   err_vaddr_q, err_vaddr_d;

  logic                       is_fencei, illegal, misaligned, accept, push, pop;
  logic                       wide;
  bp_be_dcache_pkt_s          pkt_enc;

  function automatic bp_be_dcache_op_e op_at(bp_be_dcache_op_e base, logic [3:0] off);
    return bp_be_dcache_op_e'(6'(base) + 6'(off));
  endfunction

  assign is_fencei = (io.req_class_i == 3'd5);
  assign wide      = io.req_size_i[1];

  // Classify the request: build its packet and flag illegal / misaligned combinations
  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    pkt_enc    = '0;
    pkt_enc.vaddr = io.req_vaddr_i;
    pkt_enc.data  = io.req_data_i;
    case (io.req_class_i)
      3'd0: begin
        illegal = io.req_unsigned_i & (io.req_size_i == 2'd3);
        pkt_enc.opcode = op_at(io.req_unsigned_i ? e_dcache_op_lbu : e_dcache_op_lb,
                               4'(io.req_size_i));
      end
      3'd1: begin
        illegal = io.req_unsigned_i;
        pkt_enc.opcode = op_at(e_dcache_op_sb, 4'(io.req_size_i));
      end
      3'd2, 3'd3: begin
        illegal = io.req_unsigned_i | ~wide;
        pkt_enc.opcode = op_at((io.req_class_i == 3'd2) ? e_dcache_op_lrw : e_dcache_op_scw,
                               4'(io.req_size_i[0]));
        pkt_enc.no_amo_return = io.req_no_return_i;
      end
      3'd4: begin
        illegal = io.req_unsigned_i | ~wide | (io.req_amo_i > 4'd8);
        pkt_enc.opcode = op_at(io.req_size_i[0] ? e_dcache_op_amoswapd : e_dcache_op_amoswapw,
                               io.req_amo_i);
        pkt_enc.no_amo_return = io.req_no_return_i;
      end
      3'd5: begin
        illegal = io.req_unsigned_i;
        pkt_enc.opcode = e_dcache_op_fencei;
        pkt_enc.vaddr  = '0;
        pkt_enc.data   = '0;
      end
      default: begin
        illegal = io.req_unsigned_i | ~wide;
        pkt_enc.opcode = op_at((io.req_class_i == 3'd6) ? e_dcache_op_flw : e_dcache_op_fsw,
                               4'(io.req_size_i[0]));
      end
    endcase
    case (io.req_size_i)
      2'd1:    misaligned = io.req_vaddr_i[0];
      2'd2:    misaligned = |io.req_vaddr_i[1:0];
      2'd3:    misaligned = |io.req_vaddr_i[2:0];
      default: misaligned = 1'b0;
    endcase
    if (is_fencei || illegal) misaligned = 1'b0;
  end

  assign io.req_ready_and_o = reset_n_i & (state_q == e_run) & (count_q != cnt_full)
                              & (~is_fencei | (count_q == '0));
  assign accept = io.req_v_i & io.req_ready_and_o;
  assign push   = accept & ~illegal & ~misaligned;
  assign io.pkt_v_o = (count_q != '0);
  assign io.pkt_o   = mem_q[rd_ptr_q];
  assign pop    = io.pkt_v_o & io.pkt_ready_and_i;

  assign io.err_v_o          = err_v_q;
  assign io.err_illegal_o    = err_illegal_q;
  assign io.err_misaligned_o = err_misaligned_q;
  assign io.err_vaddr_o      = err_vaddr_q;

  // FIFO pointers/storage, fence FSM and the one-cycle error report
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    state_d  = state_q;
    if (push) begin
      mem_d[wr_ptr_q] = pkt_enc;
      wr_ptr_d = (wr_ptr_q == ptr_last) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = (rd_ptr_q == ptr_last) ? '0 : rd_ptr_q + 1'b1;
    if (push && !pop) count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
    case (state_q)
      e_run:   if (push && is_fencei) state_d = e_fence;
      default: if (pop && io.pkt_o.opcode == e_dcache_op_fencei) state_d = e_run;
    endcase
    err_v_d          = accept & (illegal | misaligned);
    err_illegal_d    = accept & illegal;
    err_misaligned_d = accept & misaligned;
    err_vaddr_d      = err_v_d ? io.req_vaddr_i : '0;
  end

  // State registers; reset drops every buffered packet
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < els_p; i++) mem_q[i] <= '0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      state_q          <= e_run;
      err_v_q          <= 1'b0;
      err_illegal_q    <= 1'b0;
      err_misaligned_q <= 1'b0;
      err_vaddr_q      <= '0;
    end else begin
      mem_q            <= mem_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
      state_q          <= state_d;
      err_v_q          <= err_v_d;
      err_illegal_q    <= err_illegal_d;
      err_misaligned_q <= err_misaligned_d;
      err_vaddr_q      <= err_vaddr_d;
    end
  end

endmodule
